// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and constants for the MEM-stage data-memory
//                responder: FSM state encoding, bus widths, lane selects.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  // Halfword lane select, taken from byte-address bit 1
  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  // Byte-enable patterns for the array write port
  localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;
  localparam logic [BE_W-1:0] BE_LANE_LO = 4'b0011;
  localparam logic [BE_W-1:0] BE_LANE_HI = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte enables for a word access or for one halfword lane
  function automatic logic [BE_W-1:0] lane_be(input logic half, input logic lane);
    logic [BE_W-1:0] be;
    if (!half) begin
      be = BE_WORD;
    end else if (lane == LANE_HI) begin
      be = BE_LANE_HI;
    end else begin
      be = BE_LANE_LO;
    end
    return be;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_resp_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_resp_if
//  Description : Request/response bundle between the EX/MEM register (master)
//                and the data-memory responder (slave), including the stall.
//  Revision    : 1.0  initial release
// ============================================================================
interface dmem_resp_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_half;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              busy;

  modport master (
    output req_valid, req_write, req_half, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_half, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );

endinterface
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : Synchronous word-organised storage with a byte-enable write
//                port and a registered read port sharing one index. The read
//                register only updates on a read, so it holds the last word.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  wire logic                  i_clk,
  input  wire logic                  i_en,
  input  wire logic                  i_we,
  input  wire logic [BE_W-1:0]       i_be,
  input  wire logic [DEPTH_LOG2-1:0] i_idx,
  input  wire logic [DATA_W-1:0]     i_wdata,
  output logic      [DATA_W-1:0]     o_rdata
);

  localparam int c_DEPTH = 2 ** DEPTH_LOG2;

  logic [DATA_W-1:0] r_mem [c_DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Byte-masked write or registered read of the addressed word
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < BE_W; b++) begin
          if (i_be[b]) begin
            r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[i_idx];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_resp.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_resp
//  Description : MEM-stage data-memory responder. Accepts one load/store at a
//                time, performs a word/halfword access after LATENCY cycles,
//                returns a one-cycle completion with registered read data and
//                stalls the pipeline while a request is outstanding.
//  Options     : DMEM_ALIGN_CHECK_EN - when defined, misaligned requests are
//                flagged on resp_err and leave memory untouched; otherwise
//                the low address bits are simply ignored.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  wire logic    in_CLK,
  input  wire logic    in_RST,
  dmem_resp_if.slave   bus
);

  localparam int             c_CNT_W    = 4;
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 2);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;

  // Captured request
  logic                 r_write;
  logic                 r_half;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;

  // Response registers
  logic                 r_resp_valid;
  logic                 r_rd_zero;
  logic                 r_rd_half;
  logic                 r_rd_lane;

  logic                 w_accept;
  logic                 w_acc_go;
  logic                 w_acc_write;
  logic                 w_acc_half;
  logic [ADDR_W-1:0]    w_acc_addr;
  logic [DATA_W-1:0]    w_acc_wdata;
  logic                 w_mis;
  logic                 w_lane;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [BE_W-1:0]      w_be;
  logic [DATA_W-1:0]    w_arr_wdata;
  logic [DATA_W-1:0]    w_arr_rdata;
  logic [15:0]          w_rd_lane_data;
  logic                 w_unused;

  assign w_accept = (r_state == IDLE) && bus.req_valid;

  // The access happens on the edge that enters RESP. With LATENCY==1 that is
  // the acceptance edge itself, so the operands come straight from the bus;
  // otherwise they come from the capture registers. The upstream EX/MEM
  // register is held in reset alongside this block, so req_valid is low
  // whenever in_RST is asserted.
  assign w_acc_go    = (w_state_nxt == RESP) && (r_state != RESP);
  assign w_acc_write = (r_state == IDLE) ? bus.req_write : r_write;
  assign w_acc_half  = (r_state == IDLE) ? bus.req_half  : r_half;
  assign w_acc_addr  = (r_state == IDLE) ? bus.req_addr  : r_addr;
  assign w_acc_wdata = (r_state == IDLE) ? bus.req_wdata : r_wdata;

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_mis = w_acc_half ? w_acc_addr[0] : (w_acc_addr[1:0] != 2'b00);
`else
  assign w_mis = 1'b0;
`endif

  assign w_lane      = w_acc_addr[1];
  assign w_idx       = w_acc_addr[DEPTH_LOG2+1:2];
  assign w_be        = lane_be(w_acc_half, w_lane);
  assign w_arr_wdata = w_acc_half ? {2{w_acc_wdata[15:0]}} : w_acc_wdata;

  // Upper address bits beyond the array and the unchecked low bits are
  // intentionally don't-care.
  assign w_unused = ^w_acc_addr;

  dmem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .i_clk   (in_CLK),
    .i_en    (w_acc_go && !w_mis),
    .i_we    (w_acc_write),
    .i_be    (w_be),
    .i_idx   (w_idx),
    .i_wdata (w_arr_wdata),
    .o_rdata (w_arr_rdata)
  );

  // State and latency counter register
  always_ff @(posedge in_CLK or negedge in_RST) begin
    if (!in_RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: IDLE accepts, WAIT counts down to 0, RESP lasts one cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          if (LATENCY == 1) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = c_CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Capture the request on acceptance; later bus changes are ignored
  always_ff @(posedge in_CLK or negedge in_RST) begin
    if (!in_RST) begin
      r_write <= 1'b0;
      r_half  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_write <= bus.req_write;
      r_half  <= bus.req_half;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
    end
  end

  // Completion pulse and read-data formatting state; stores leave it alone
  always_ff @(posedge in_CLK or negedge in_RST) begin
    if (!in_RST) begin
      r_resp_valid <= 1'b0;
      r_rd_zero    <= 1'b1;
      r_rd_half    <= 1'b0;
      r_rd_lane    <= LANE_LO;
    end else begin
      r_resp_valid <= w_acc_go;
      if (w_acc_go) begin
        if (w_mis) begin
          r_rd_zero <= 1'b1;
        end else if (!w_acc_write) begin
          r_rd_zero <= 1'b0;
          r_rd_half <= w_acc_half;
          r_rd_lane <= w_lane;
        end
      end
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic r_err;

  // Misalignment flag, held until the next completion
  always_ff @(posedge in_CLK or negedge in_RST) begin
    if (!in_RST) begin
      r_err <= 1'b0;
    end else if (w_acc_go) begin
      r_err <= w_mis;
    end
  end

  assign bus.resp_err = r_err;
`else
  assign bus.resp_err = 1'b0;
`endif

  // Lane mux works only on registered state, so resp_rdata has no input path
  assign w_rd_lane_data = (r_rd_lane == LANE_LO) ? w_arr_rdata[15:0] : w_arr_rdata[31:16];

  assign bus.resp_rdata = r_rd_zero ? '0 :
                          r_rd_half ? {16'h0000, w_rd_lane_data} : w_arr_rdata;
  assign bus.resp_valid = r_resp_valid;
  assign bus.req_ready  = (r_state == IDLE);
  assign bus.busy       = (r_state == WAIT) || ((r_state == IDLE) && bus.req_valid);

endmodule
`default_nettype wire

// File: tb/tb_dmem_resp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_resp
//  Description : Self-checking bench for dmem_resp: directed vector table,
//                back-to-back and reset-abort sequences, then randomized
//                requests against a word-array reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_resp;
  import dmem_pkg::*;

  localparam int LAT  = 2;
  localparam int DLOG = 10;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_resp_if bus();

  dmem_resp #(
    .DEPTH_LOG2 (DLOG),
    .LATENCY    (LAT)
  ) dut (
    .in_CLK (clk),
    .in_RST (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: word array plus the held response values
  logic [31:0] m_mem [int];
  logic [31:0] m_rdata;
  logic        m_err;

  function automatic void model_reset();
    m_rdata = 32'h0;
    m_err   = 1'b0;
  endfunction

  function automatic void model_apply(input logic w, input logic h,
                                      input logic [11:0] a, input logic [31:0] d);
    int          idx;
    logic        mis;
    logic [31:0] word;
    idx = (int'(a) / 4) % (1 << DLOG);
    mis = ALIGN && (h ? a[0] : (a[1:0] != 2'b00));
    if (mis) begin
      m_err   = 1'b1;
      m_rdata = 32'h0;
    end else begin
      m_err = 1'b0;
      word  = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
      if (w) begin
        if (!h)       m_mem[idx] = d;
        else if (a[1]) m_mem[idx] = {d[15:0], word[15:0]};
        else           m_mem[idx] = {word[31:16], d[15:0]};
      end else begin
        if (!h)        m_rdata = word;
        else if (a[1]) m_rdata = {16'h0, word[31:16]};
        else           m_rdata = {16'h0, word[15:0]};
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One request: waits for ready, checks latency, busy and pulse width
  task automatic do_req(input string nm, input logic w, input logic h,
                        input logic [11:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er);
    int c;
    bit seen;
    rd = 32'h0;
    er = 1'b0;
    c  = 0;
    while (bus.req_ready !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk({nm, " ready"}, 32'(bus.req_ready), 32'(1));
    bus.req_write = w;
    bus.req_half  = h;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_valid = 1'b1;
    #1;
    chk({nm, " busy idle"}, 32'(bus.busy), 32'(1));
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom_range(0, 1));
    bus.req_half  = 1'($urandom_range(0, 1));
    bus.req_addr  = 12'($urandom);
    bus.req_wdata = $urandom;
    seen = 1'b0;
    c    = 0;
    for (int k = 1; k <= LAT + 4 && !seen; k++) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) begin
        seen = 1'b1;
        c    = k;
        rd   = bus.resp_rdata;
        er   = bus.resp_err;
        chk({nm, " busy resp"}, 32'(bus.busy), 32'(0));
      end else if (k < LAT) begin
        chk({nm, " busy wait"}, 32'(bus.busy), 32'(1));
      end
    end
    chk({nm, " latency"}, 32'(c), 32'(LAT));
    @(negedge clk);
    chk({nm, " pulse end"}, 32'({bus.resp_valid, bus.req_ready}), 32'(2'b01));
  endtask

  typedef struct {
    logic        w;
    logic        h;
    logic [15:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic h, input logic [15:0] a,
                              input logic [31:0] d, input logic [31:0] e, input logic er);
    vec_t v;
    v.w = w; v.h = h; v.a = a; v.d = d; v.exp_rd = e; v.exp_err = er;
    return v;
  endfunction

  localparam int NV = 17;
  vec_t vecs [NV];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        w, h;
    logic [11:0] a;
    logic [31:0] d;
    int          p, k, g;
    logic [11:0] b_addr [3];
    logic        b_half [3];
    logic [31:0] b_exp  [3];

    // Directed vectors: {write, half, addr, wdata, expected rdata, expected err}
    vecs[0]  = mk(1, 0, 16'h0010, 32'hDEADBEEF, 32'h00000000, 0);
    vecs[1]  = mk(0, 0, 16'h0010, 32'h0,        32'hDEADBEEF, 0);
    vecs[2]  = mk(1, 1, 16'h0012, 32'hFFFF1234, 32'hDEADBEEF, 0);
    vecs[3]  = mk(0, 0, 16'h0010, 32'h0,        32'h1234BEEF, 0);
    vecs[4]  = mk(0, 1, 16'h0010, 32'h0,        32'h0000BEEF, 0);
    vecs[5]  = mk(0, 1, 16'h0012, 32'h0,        32'h00001234, 0);
    vecs[6]  = mk(0, 0, 16'h0013, 32'h0,        ALIGN ? 32'h0 : 32'h1234BEEF, ALIGN);
    vecs[7]  = mk(0, 0, 16'h0010, 32'h0,        32'h1234BEEF, 0);
    vecs[8]  = mk(1, 0, 16'h1010, 32'hCAFEF00D, 32'h1234BEEF, 0);
    vecs[9]  = mk(0, 0, 16'h0010, 32'h0,        32'hCAFEF00D, 0);
    vecs[10] = mk(1, 0, 16'h0020, 32'h11111111, 32'hCAFEF00D, 0);
    vecs[11] = mk(1, 1, 16'h0021, 32'hAAAA5555, ALIGN ? 32'h0 : 32'hCAFEF00D, ALIGN);
    vecs[12] = mk(0, 0, 16'h0020, 32'h0,        ALIGN ? 32'h11111111 : 32'h11115555, 0);
    vecs[13] = mk(1, 0, 16'h0014, 32'h55AA55AA, ALIGN ? 32'h11111111 : 32'h11115555, 0);
    vecs[14] = mk(1, 0, 16'h0016, 32'h77777777, ALIGN ? 32'h0 : 32'h11115555, ALIGN);
    vecs[15] = mk(0, 0, 16'h0014, 32'h0,        ALIGN ? 32'h55AA55AA : 32'h77777777, 0);
    vecs[16] = mk(0, 1, 16'h0016, 32'h0,        ALIGN ? 32'h000055AA : 32'h00007777, 0);

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_half  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset resp_valid", 32'(bus.resp_valid), 32'(0));
    chk("reset resp_rdata", bus.resp_rdata, 32'h0);
    chk("reset resp_err",   32'(bus.resp_err), 32'(0));
    chk("reset req_ready",  32'(bus.req_ready), 32'(1));
    chk("reset busy",       32'(bus.busy), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven directed checks
    for (int i = 0; i < NV; i++) begin
      do_req($sformatf("vec%0d", i), vecs[i].w, vecs[i].h, vecs[i].a[11:0], vecs[i].d, rd, er);
      model_apply(vecs[i].w, vecs[i].h, vecs[i].a[11:0], vecs[i].d);
      chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
    end

    // Back-to-back loads with req_valid held high
    b_addr[0] = 12'h010; b_half[0] = 1'b0;
    b_addr[1] = 12'h020; b_half[1] = 1'b0;
    b_addr[2] = 12'h012; b_half[2] = 1'b1;
    bus.req_write = 1'b0;
    bus.req_half  = b_half[0];
    bus.req_addr  = b_addr[0];
    bus.req_valid = 1'b1;
    for (int i = 0; i < 3 * (LAT + 1); i++) begin
      p = i % (LAT + 1);
      k = i / (LAT + 1);
      #1;
      chk("b2b ready",      32'(bus.req_ready), 32'(p == 0));
      chk("b2b busy",       32'(bus.busy), 32'(p != LAT));
      chk("b2b resp_valid", 32'(bus.resp_valid), 32'(p == LAT));
      if (p == 0) begin
        model_apply(1'b0, b_half[k], b_addr[k], 32'h0);
        b_exp[k] = m_rdata;
      end
      if (p == LAT) begin
        chk($sformatf("b2b rdata%0d", k), bus.resp_rdata, b_exp[k]);
        bus.req_write = 1'b0;
        if (k < 2) begin
          bus.req_half = b_half[k+1];
          bus.req_addr = b_addr[k+1];
        end else begin
          bus.req_valid = 1'b0;
        end
      end else if (p != 0) begin
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_half  = 1'($urandom_range(0, 1));
        bus.req_addr  = 12'($urandom);
      end
      @(negedge clk);
    end

    // Reset during WAIT of a store: must be discarded entirely
    bus.req_write = 1'b1;
    bus.req_half  = 1'b0;
    bus.req_addr  = 12'h020;
    bus.req_wdata = 32'h0;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("abort busy in wait", 32'(bus.busy), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("abort ready", 32'(bus.req_ready), 32'(1));
    chk("abort busy",  32'(bus.busy), 32'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort no resp_valid", 32'(bus.resp_valid), 32'(0));
    end
    chk("abort rdata cleared", bus.resp_rdata, 32'h0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    do_req("abort load", 1'b0, 1'b0, 12'h020, 32'h0, rd, er);
    model_apply(1'b0, 1'b0, 12'h020, 32'h0);
    chk("abort old value", rd, m_rdata);
    chk("abort err", 32'(er), 32'(m_err));

    // Randomized traffic over a 16-word region, region preloaded first
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      do_req("init", 1'b1, 1'b0, 12'(i * 4), d, rd, er);
      model_apply(1'b1, 1'b0, 12'(i * 4), d);
      chk("init err", 32'(er), 32'(m_err));
    end
    for (int n = 0; n < 150; n++) begin
      w = 1'($urandom_range(0, 1));
      h = 1'($urandom_range(0, 1));
      a = 12'($urandom_range(0, 63));
      d = $urandom;
      g = $urandom_range(0, 2);
      repeat (g) @(negedge clk);
      do_req("rnd", w, h, a, d, rd, er);
      model_apply(w, h, a, d);
      chk($sformatf("rnd%0d rdata w=%0d h=%0d a=%h", n, w, h, a), rd, m_rdata);
      chk($sformatf("rnd%0d err", n), 32'(er), 32'(m_err));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
